// File: rtl/cell_sweep_pkg.sv
// Shared types, widths and default constants for the cell_sweep stimulus
// sequencer and its signature register.
package cell_sweep_pkg;

  localparam int VEC_W  = 6;
  localparam int PAGE_W = 5;
  localparam int SIG_W  = 16;
  localparam int RESP_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [SIG_W-1:0] DEF_SIG_SEED = 16'hFFFF;
  localparam logic [SIG_W-1:0] DEF_SIG_POLY = 16'h1021;

  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } sweep_state_t;

  // One MISR step: shift left, fold the polynomial when the MSB falls out,
  // then inject the 8-bit response into the low byte.
  function automatic logic [SIG_W-1:0] misr_next(
    input logic [SIG_W-1:0]  sig,
    input logic [SIG_W-1:0]  poly,
    input logic [RESP_W-1:0] data
  );
    logic [SIG_W-1:0] nxt;
    nxt = {sig[SIG_W-2:0], 1'b0};
    if (sig[SIG_W-1]) nxt = nxt ^ poly;
    nxt = nxt ^ {{(SIG_W-RESP_W){1'b0}}, data};
    return nxt;
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register folding cell responses into a signature.
module sweep_misr
  import cell_sweep_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              enable,
  input  logic [SIG_W-1:0]  seed,
  input  logic [SIG_W-1:0]  poly,
  input  logic [RESP_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  // Signature register: load (seed) takes precedence over a compaction step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (!rst_n) begin
      sig <= seed;
    end else if (load) begin
      sig <= seed;
    end else if (enable) begin
      sig <= misr_next(sig, poly, data);
    end
  end

endmodule

// File: rtl/cell_sweep.sv
// Self-timed sequencer: walks all 64 input vectors of one cell_mux page,
// holding each for SETTLE_CYCLES before compacting the response.
module cell_sweep
  import cell_sweep_pkg::*;
#(
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [SIG_W-1:0] SIG_SEED      = DEF_SIG_SEED,
  parameter logic [SIG_W-1:0] SIG_POLY      = DEF_SIG_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [PAGE_W-1:0] page_sel,
  input  logic [RESP_W-1:0] cell_out,
  output logic [PAGE_W-1:0] page,
  output logic [VEC_W-1:0]  stim,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  sweep_state_t     state;
  logic [CNT_W-1:0] settle_cnt;
  logic             start_ok;
  logic             misr_load;
  logic             misr_en;

  // Start is only honoured while not busy; abort and start both reseed the MISR.
  // NOTE: every output of this block is a plain continuous expression, so no
  // path can leave a signal unassigned and infer a latch.
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign misr_load = abort || start_ok;
  assign misr_en   = (state == CAPTURE) && !abort;

  // Sweep FSM with settle and vector counters; outputs registered with state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      page       <= '0;
      stim       <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      // Abort wins over everything; page is intentionally retained.
      state      <= IDLE;
      stim       <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            page       <= page_sel;
            stim       <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (stim == VEC_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            stim       <= stim + 1'b1;
            settle_cnt <= '0;
            state      <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sweep_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (misr_load),
    .enable (misr_en),
    .seed   (SIG_SEED),
    .poly   (SIG_POLY),
    .data   (cell_out),
    .sig    (signature)
  );

endmodule
